// File: rtl/uart_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_axi_pkg
// Purpose  : Shared opcodes, AXI constants and frame FSM states for the
//            UART-to-AXI master bridge.
// Revision : 1.0  initial release
// ============================================================================
package uart_axi_pkg;

  // Command opcodes and negative acknowledge byte
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] NAK   = 8'h3F;

  // Fixed single-beat 32-bit AXI attributes
  localparam logic [7:0] LEN0       = 8'h00;
  localparam logic [2:0] SIZE4B     = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Frame FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_WR_AW_W  = 3'd3,
    ST_WR_B     = 3'd4,
    ST_RD_AR    = 3'd5,
    ST_RD_R     = 3'd6,
    ST_SEND     = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_8n1.sv
`default_nettype none
// ============================================================================
// Module   : uart_8n1
// Purpose  : 8N1 UART receiver (with synchroniser, glitch rejection and
//            framing-error flag) and back-to-back capable transmitter.
// Revision : 1.0  initial release
// ============================================================================
module uart_8n1 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_stb,
  output logic       o_rx_ferr,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_start,
  output logic       o_tx_busy
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);

  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic          r_rx_busy;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_sr, r_rx_byte;
  logic          r_rx_stb, r_rx_ferr;

  logic          r_tx_busy;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [9:0]    r_tx_sr;
  logic          w_tx_last;

  assign o_rx_byte = r_rx_byte;
  assign o_rx_stb  = r_rx_stb;
  assign o_rx_ferr = r_rx_ferr;

  // Two-flop synchroniser on the asynchronous line plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Receiver: bit index 0 is the start bit (checked at half period), 1..8 data, 9 stop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_busy <= 1'b0;
      r_rx_cnt  <= '0;
      r_rx_bit  <= 4'd0;
      r_rx_sr   <= 8'h00;
      r_rx_byte <= 8'h00;
      r_rx_stb  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      r_rx_stb  <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_prev && !r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= '0;
          r_rx_bit  <= 4'd0;
        end
      end else if (r_rx_bit == 4'd0) begin
        if (r_rx_cnt == C_HALF) begin
          r_rx_cnt <= '0;
          if (r_rx_s2) r_rx_busy <= 1'b0;   // line back high: glitch
          else         r_rx_bit  <= 4'd1;
        end else begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
        end
      end else if (r_rx_cnt == C_FULL) begin
        r_rx_cnt <= '0;
        if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_s2) begin
            r_rx_byte <= r_rx_sr;
            r_rx_stb  <= 1'b1;
          end else begin
            r_rx_ferr <= 1'b1;
          end
        end else begin
          r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
          r_rx_bit <= r_rx_bit + 1'b1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
    end
  end

  // Busy drops in the final stop-bit cycle so the next byte can follow with no gap
  assign w_tx_last = r_tx_busy && (r_tx_cnt == C_FULL) && (r_tx_bit == 4'd9);
  assign o_tx_busy = r_tx_busy && !w_tx_last;
  assign o_tx      = r_tx_busy ? r_tx_sr[0] : 1'b1;

  // Transmitter: shifts {stop, data, start} out LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_busy <= 1'b0;
      r_tx_cnt  <= '0;
      r_tx_bit  <= 4'd0;
      r_tx_sr   <= 10'h3FF;
    end else if (i_tx_start && !o_tx_busy) begin
      r_tx_sr   <= {1'b1, i_tx_byte, 1'b0};
      r_tx_busy <= 1'b1;
      r_tx_cnt  <= '0;
      r_tx_bit  <= 4'd0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == C_FULL) begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx_bit <= r_tx_bit + 1'b1;
          r_tx_sr  <= {1'b1, r_tx_sr[9:1]};
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_axi_master
// Purpose  : Decodes framed UART commands into single-beat AXI4 writes and
//            reads and returns status / read data over UART.
// Revision : 1.0  initial release
// ============================================================================
module uart_axi_master
  import uart_axi_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Rx,
  output logic        Tx,
  output logic [31:0] AW_add,
  output logic        AW_valid,
  input  logic        AW_ready,
  output logic [7:0]  AW_len,
  output logic [2:0]  AW_size,
  output logic [1:0]  AW_burst,
  output logic [31:0] W_data,
  output logic [3:0]  W_strb,
  output logic        W_valid,
  output logic        W_last,
  input  logic        W_ready,
  input  logic [1:0]  B_response,
  input  logic        B_valid,
  output logic        B_ready,
  output logic [31:0] AR_add,
  output logic        AR_valid,
  input  logic        AR_ready,
  output logic [7:0]  AR_len,
  output logic [2:0]  AR_size,
  output logic [1:0]  AR_burst,
  input  logic [31:0] R_data,
  input  logic [1:0]  R_resp,
  input  logic        R_valid,
  input  logic        R_last,
  output logic        R_ready
);

  localparam int            CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int            TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] C_TIMEOUT    = TW'(TIMEOUT_CLKS - 1);

  state_t        r_state, w_next;
  logic [31:0]   r_addr, r_data, r_rdata;
  logic [1:0]    r_cnt, r_rresp;
  logic          r_is_wr, r_aw_done, r_w_done, r_first;
  logic [TW-1:0] r_timer;
  logic [39:0]   r_send_buf;
  logic [2:0]    r_send_left;

  logic [7:0]    w_rx_byte;
  logic          w_rx_stb, w_rx_ferr, w_tx_busy, w_tx_start;
  logic          w_aw_hs, w_w_hs;

  uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk        (Clk),
    .rst        (Rst),
    .i_rx       (Rx),
    .o_tx       (Tx),
    .o_rx_byte  (w_rx_byte),
    .o_rx_stb   (w_rx_stb),
    .o_rx_ferr  (w_rx_ferr),
    .i_tx_byte  (r_send_buf[39:32]),
    .i_tx_start (w_tx_start),
    .o_tx_busy  (w_tx_busy)
  );

  assign AW_add   = r_addr;
  assign AR_add   = r_addr;
  assign W_data   = r_data;
  assign AW_len   = LEN0;
  assign AR_len   = LEN0;
  assign AW_size  = SIZE4B;
  assign AR_size  = SIZE4B;
  assign AW_burst = BURST_INCR;
  assign AR_burst = BURST_INCR;
  assign W_strb   = 4'hF;
  assign W_last   = W_valid;
  assign w_aw_hs  = AW_valid && AW_ready;
  assign w_w_hs   = W_valid && W_ready;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next     = r_state;
    AW_valid   = 1'b0;
    W_valid    = 1'b0;
    B_ready    = 1'b0;
    AR_valid   = 1'b0;
    R_ready    = 1'b0;
    w_tx_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_stb)
          w_next = (w_rx_byte == OP_WR || w_rx_byte == OP_RD) ? ST_GET_ADDR : ST_SEND;
      end
      ST_GET_ADDR: begin
        if (w_rx_ferr || (!w_rx_stb && r_timer == C_TIMEOUT)) w_next = ST_IDLE;
        else if (w_rx_stb && r_cnt == 2'd3) w_next = r_is_wr ? ST_GET_DATA : ST_RD_AR;
      end
      ST_GET_DATA: begin
        if (w_rx_ferr || (!w_rx_stb && r_timer == C_TIMEOUT)) w_next = ST_IDLE;
        else if (w_rx_stb && r_cnt == 2'd3) w_next = ST_WR_AW_W;
      end
      ST_WR_AW_W: begin
        AW_valid = !r_aw_done;
        W_valid  = !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = ST_WR_B;
      end
      ST_WR_B: begin
        B_ready = 1'b1;
        if (B_valid) w_next = ST_SEND;
      end
      ST_RD_AR: begin
        AR_valid = 1'b1;
        if (AR_ready) w_next = ST_RD_R;
      end
      ST_RD_R: begin
        R_ready = 1'b1;
        if (R_valid && R_last) w_next = ST_SEND;
      end
      ST_SEND: begin
        w_tx_start = (r_send_left != 3'd0) && !w_tx_busy;
        if (r_send_left == 3'd0 && !w_tx_busy) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Frame assembly, handshake bookkeeping and response buffer
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_addr      <= 32'h0;
      r_data      <= 32'h0;
      r_rdata     <= 32'h0;
      r_rresp     <= RESP_OKAY;
      r_cnt       <= 2'd0;
      r_is_wr     <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_first     <= 1'b0;
      r_timer     <= '0;
      r_send_buf  <= 40'h0;
      r_send_left <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rx_stb) begin
            r_is_wr     <= (w_rx_byte == OP_WR);
            r_cnt       <= 2'd0;
            r_timer     <= '0;
            r_send_buf  <= {NAK, 32'h0};   // only used if the opcode is unknown
            r_send_left <= 3'd1;
          end
        end
        ST_GET_ADDR, ST_GET_DATA: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (w_rx_stb) begin
            r_timer <= '0;
            r_cnt   <= r_cnt + 1'b1;
            if (r_state == ST_GET_ADDR) r_addr <= {r_addr[23:0], w_rx_byte};
            else                        r_data <= {r_data[23:0], w_rx_byte};
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WR_AW_W: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        ST_WR_B: begin
          if (B_valid) begin
            r_send_buf  <= {6'b0, B_response, 32'h0};
            r_send_left <= 3'd1;
          end
        end
        ST_RD_AR: r_first <= 1'b1;
        ST_RD_R: begin
          if (R_valid) begin
            r_first <= 1'b0;
            if (r_first) begin
              r_rdata <= R_data;
              r_rresp <= R_resp;
            end
            if (R_last) begin
              r_send_buf  <= r_first ? {6'b0, R_resp, R_data} : {6'b0, r_rresp, r_rdata};
              r_send_left <= 3'd5;
            end
          end
        end
        ST_SEND: begin
          if (w_tx_start) begin
            r_send_buf  <= {r_send_buf[31:0], 8'h00};
            r_send_left <= r_send_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_axi_master
// Purpose  : Self-checking bench for uart_axi_master with a UART host, an
//            AXI slave model and a frame-level response model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_axi_master;

  localparam int CPB = 16;

  logic        Clk = 1'b0, Rst = 1'b1, Rx = 1'b1, Tx;
  logic [31:0] AW_add, W_data, AR_add, R_data;
  logic        AW_valid, AW_ready, W_valid, W_last, W_ready, B_valid, B_ready;
  logic        AR_valid, AR_ready, R_valid, R_last, R_ready;
  logic [7:0]  AW_len, AR_len;
  logic [2:0]  AW_size, AR_size;
  logic [1:0]  AW_burst, AR_burst, B_response, R_resp;
  logic [3:0]  W_strb;

  uart_axi_master #(.CLK_FREQ(1600000), .BAUD(100000), .TIMEOUT_CLKS(1000)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Tx(Tx),
    .AW_add(AW_add), .AW_valid(AW_valid), .AW_ready(AW_ready), .AW_len(AW_len),
    .AW_size(AW_size), .AW_burst(AW_burst),
    .W_data(W_data), .W_strb(W_strb), .W_valid(W_valid), .W_last(W_last), .W_ready(W_ready),
    .B_response(B_response), .B_valid(B_valid), .B_ready(B_ready),
    .AR_add(AR_add), .AR_valid(AR_valid), .AR_ready(AR_ready), .AR_len(AR_len),
    .AR_size(AR_size), .AR_burst(AR_burst),
    .R_data(R_data), .R_resp(R_resp), .R_valid(R_valid), .R_last(R_last), .R_ready(R_ready)
  );

  initial forever #5 Clk = ~Clk;

  int tests = 0, fails = 0;

  // Slave configuration and observation
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_beats = 1;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0, valid_any = 0, unstable = 0, wlast_bad = 0;
  logic [31:0] aw_seen = 0, w_seen = 0, ar_seen = 0;
  logic [7:0]  rxq[$];
  int          tx_stop_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART host receiver: decodes bytes the DUT sends on Tx
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge Clk);
      if (!Rst && Tx === 1'b0) begin
        repeat (CPB / 2) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge Clk);
          b[i] = Tx;
        end
        repeat (CPB) @(negedge Clk);
        if (Tx !== 1'b1) tx_stop_bad++;
        rxq.push_back(b);
      end
    end
  end

  // AXI slave model: inputs change on the falling edge, DUT samples on the rising edge
  initial begin
    int aw_w = 0, w_w = 0, ar_w = 0, beat = 0;
    bit pend = 0;
    AW_ready = 0; W_ready = 0; AR_ready = 0; B_valid = 0; B_response = 0;
    R_valid = 0; R_last = 0; R_data = 0; R_resp = 0;
    forever begin
      @(negedge Clk);
      if (AW_valid || W_valid || AR_valid) valid_any++;
      if (W_last !== W_valid) wlast_bad++;
      if (AW_valid) begin
        if (aw_w > 0 && AW_add !== aw_seen) unstable++;
        aw_seen = AW_add; aw_cyc++;
        AW_ready = (aw_w >= aw_delay); aw_w++;
      end else begin AW_ready = 0; aw_w = 0; end
      if (W_valid) begin
        if (w_w > 0 && W_data !== w_seen) unstable++;
        w_seen = W_data; w_cyc++;
        W_ready = (w_w >= w_delay); w_w++;
      end else begin W_ready = 0; w_w = 0; end
      if (AR_valid) begin
        if (ar_w > 0 && AR_add !== ar_seen) unstable++;
        ar_seen = AR_add; ar_cyc++;
        AR_ready = (ar_w >= ar_delay); ar_w++;
      end else begin AR_ready = 0; ar_w = 0; end
      B_valid = B_ready; B_response = b_resp_cfg;
      if (!R_ready) begin
        beat = 0; pend = 0; R_valid = 0; R_last = 0;
      end else begin
        if (pend) beat++;
        R_valid = 1;
        R_last  = (beat >= r_beats - 1);
        R_data  = (beat == 0) ? r_data_cfg : $urandom;
        R_resp  = (beat == 0) ? r_resp_cfg : 2'($urandom);
        pend    = 1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    Rx = 1'b0; repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin Rx = b[i]; repeat (CPB) @(negedge Clk); end
    Rx = stop; repeat (CPB) @(negedge Clk);
    Rx = 1'b1;
  endtask

  task automatic clear_obs();
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0; valid_any = 0; unstable = 0;
    rxq.delete();
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k = 0;
    while (rxq.size() < n && k < 6000) begin @(negedge Clk); k++; end
    repeat (200) @(negedge Clk);
    check({tag, "_nbytes"}, rxq.size(), n);
  endtask

  // One command frame; expected response bytes come from the frame rules
  task automatic run_txn(input string tag, input bit is_wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] resp,
                         input int d1, input int d2, input int beats);
    logic [7:0] exp[$];
    clear_obs();
    b_resp_cfg = resp; r_resp_cfg = resp; r_data_cfg = data; r_beats = beats;
    aw_delay = d1; w_delay = d2; ar_delay = d1;
    send_byte(is_wr ? 8'h57 : 8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(8'((addr >> (8 * i)) & 32'hFF), 1'b1);
    exp.push_back({6'b0, resp});
    if (is_wr) for (int i = 3; i >= 0; i--) send_byte(8'((data >> (8 * i)) & 32'hFF), 1'b1);
    else       for (int i = 3; i >= 0; i--) exp.push_back(8'((data >> (8 * i)) & 32'hFF));
    wait_bytes(tag, exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < rxq.size()) ? rxq[i] : 8'hxx, exp[i]);
    if (is_wr) begin
      check({tag, "_awaddr"}, aw_seen, addr);
      check({tag, "_wdata"}, w_seen, data);
      check({tag, "_no_ar"}, ar_cyc, 0);
    end else begin
      check({tag, "_araddr"}, ar_seen, addr);
      check({tag, "_no_aw"}, aw_cyc + w_cyc, 0);
    end
    check({tag, "_stable"}, unstable, 0);
  endtask

  initial begin
    int k;
    repeat (4) @(negedge Clk);
    check("rst_tx", Tx, 1'b1);
    check("rst_valids", {AW_valid, W_valid, AR_valid, B_ready, R_ready}, 5'b0);
    check("rst_awadd", AW_add, 32'h0);
    check("rst_wdata", W_data, 32'h0);
    check("rst_aradd", AR_add, 32'h0);
    check("const_aw", {AW_len, AW_size, AW_burst}, {8'h00, 3'b010, 2'b01});
    check("const_ar", {AR_len, AR_size, AR_burst}, {8'h00, 3'b010, 2'b01});
    check("const_strb", W_strb, 4'hF);
    Rst = 1'b0;
    repeat (5) @(negedge Clk);

    run_txn("wr", 1'b1, 32'h12345678, 32'hDEADBEEF, 2'b00, 0, 0, 1);
    check("wr_awcyc", aw_cyc, 1);
    run_txn("rd", 1'b0, 32'h00000100, 32'hCAFEF00D, 2'b00, 0, 0, 1);
    run_txn("skew", 1'b1, $urandom, $urandom, 2'b10, 5, 0, 1);
    check("skew_awcyc", aw_cyc, 6);
    check("skew_wcyc", w_cyc, 1);

    // Unknown opcode
    clear_obs();
    send_byte(8'h41, 1'b1);
    wait_bytes("badop", 1);
    check("badop_nak", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'h3F);
    check("badop_noaxi", valid_any, 0);
    run_txn("after_badop", 1'b0, $urandom, $urandom, 2'($urandom), 0, 0, 1);

    // Inter-byte timeout
    clear_obs();
    send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    repeat (1200) @(negedge Clk);
    check("tmo_noaxi", valid_any, 0);
    check("tmo_notx", rxq.size(), 0);
    run_txn("after_tmo", 1'b1, $urandom, $urandom, 2'($urandom), 1, 2, 1);

    // Framing error mid-frame
    clear_obs();
    send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hAA, 1'b0);
    repeat (100) @(negedge Clk);
    check("ferr_noaxi", valid_any, 0);
    check("ferr_notx", rxq.size(), 0);
    run_txn("after_ferr", 1'b0, $urandom, $urandom, 2'($urandom), 2, 0, 3);

    // Randomised traffic
    for (int t = 0; t < 6; t++)
      run_txn($sformatf("rnd%0d", t), 1'($urandom), $urandom, $urandom, 2'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 3));

    // Reset while the write address is outstanding
    clear_obs();
    aw_delay = 1000; w_delay = 1000;
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
    k = 0;
    while (!AW_valid && k < 3000) begin @(negedge Clk); k++; end
    check("rst_aw_reached", AW_valid, 1'b1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check("midrst_valids", {AW_valid, W_valid, AR_valid, B_ready, R_ready}, 5'b0);
    check("midrst_tx", Tx, 1'b1);
    check("midrst_awadd", AW_add, 32'h0);
    @(negedge Clk); Rst = 1'b0;
    rxq.delete();
    repeat (400) @(negedge Clk);
    check("midrst_notx", rxq.size(), 0);
    run_txn("after_rst", 1'b1, $urandom, $urandom, 2'($urandom), 0, 3, 1);

    check("wlast_tracks", wlast_bad, 0);
    check("tx_stopbits", tx_stop_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
